aclk_keyreg_n: RTL and testbench

Parametrised keypad digit-entry buffer for the alarm clock; successor to the fixed 4-digit key shift register.
- Accepts BCD keys into a DIGITS-deep left-shifting buffer.
- Adds backspace, clear, parallel preload, digit counting, key validation and a registered commit handshake.
- Sits between the keypad scanner/debouncer and the alarm/time registers.

---
 rtl/aclk_keyreg_n_if.sv | 44 ++++
 rtl/aclk_keyreg_n.sv | 120 ++++++++++++
 tb/tb_aclk_keyreg_n.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aclk_keyreg_n_if.sv
// Keypad buffer bus: entry controls from the keypad side, buffer and commit status back.
// Defining KEYREG_TIMEOUT_EN adds the idle-timeout pulse.
interface aclk_keyreg_n_if #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned DIGIT_W = 4
);
  localparam int unsigned BW = DIGITS * DIGIT_W;
  localparam int unsigned CW = $clog2(DIGITS + 1);

  logic [DIGIT_W-1:0] key;
  logic               shift;
  logic               backspace;
  logic               clear;
  logic               load;
  logic [BW-1:0]      load_value;
  logic               commit;

  logic [BW-1:0]      key_buffer;
  logic [CW-1:0]      digit_count;
  logic               buf_full;
  logic               commit_valid;
  logic [BW-1:0]      commit_value;
  logic               overflow;
  logic               key_reject;
`ifdef KEYREG_TIMEOUT_EN
  logic               timeout;
`endif

  modport master (
    output key, shift, backspace, clear, load, load_value, commit,
    input  key_buffer, digit_count, buf_full, commit_valid, commit_value, overflow, key_reject
`ifdef KEYREG_TIMEOUT_EN
    , input timeout
`endif
  );

  modport slave (
    input  key, shift, backspace, clear, load, load_value, commit,
    output key_buffer, digit_count, buf_full, commit_valid, commit_value, overflow, key_reject
`ifdef KEYREG_TIMEOUT_EN
    , output timeout
`endif
  );
endinterface

// File: rtl/aclk_keyreg_n.sv
// Keypad digit-entry buffer: keys shift in at digit 0, with backspace, clear, preload and a
// registered commit snapshot. Define KEYREG_TIMEOUT_EN to auto-clear after TIMEOUT_CYCLES idle.
module aclk_keyreg_n #(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned DIGIT_W         = 4,
  parameter int unsigned MAX_KEY         = 9,
  parameter bit          CLEAR_ON_COMMIT = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES  = 50000000
) (
  input logic            clk,
  input logic            reset,
  aclk_keyreg_n_if.slave bus
);
  localparam int unsigned BW = DIGITS * DIGIT_W;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] FullCnt = CW'(DIGITS);

  logic [BW-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] cval_q, cval_d;
  logic          cvalid_q;
  logic          ovf_q, ovf_d;
  logic          rej_q, rej_d;
  logic          key_ok;
  logic          commit_clr;

`ifdef KEYREG_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] IdleLast = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] idle_q, idle_d;
  logic          to_q;
  logic          user_evt;
  logic          expire;
`endif

  always_comb begin
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    ovf_d      = 1'b0;
    rej_d      = 1'b0;
    key_ok     = (32'(bus.key) <= MAX_KEY);
    commit_clr = bus.commit && CLEAR_ON_COMMIT;
    // Snapshot uses the pre-update buffer regardless of what else happens this cycle.
    cval_d     = bus.commit ? buf_q : cval_q;

    if (bus.clear || commit_clr) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (bus.load) begin
      buf_d = bus.load_value;
      cnt_d = FullCnt;
    end else if (bus.backspace) begin
      if (cnt_q != '0) begin
        buf_d = {{DIGIT_W{1'b0}}, buf_q[BW-1:DIGIT_W]};
        cnt_d = cnt_q - 1'b1;
      end
    end else if (bus.shift) begin
      if (key_ok) begin
        buf_d = {buf_q[BW-DIGIT_W-1:0], bus.key};
        if (cnt_q == FullCnt) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        rej_d = 1'b1;
      end
    end

`ifdef KEYREG_TIMEOUT_EN
    user_evt = bus.clear || bus.load || bus.commit || (bus.backspace && (cnt_q != '0)) ||
               (bus.shift && key_ok);
    expire   = !user_evt && (cnt_q != '0) && (idle_q == IdleLast);
    if (expire) begin
      buf_d = '0;
      cnt_d = '0;
    end
    idle_d = (user_evt || (cnt_q == '0) || expire) ? '0 : idle_q + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q    <= '0;
      cnt_q    <= '0;
      cval_q   <= '0;
      cvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      rej_q    <= 1'b0;
`ifdef KEYREG_TIMEOUT_EN
      idle_q   <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      cval_q   <= cval_d;
      cvalid_q <= bus.commit;
      ovf_q    <= ovf_d;
      rej_q    <= rej_d;
`ifdef KEYREG_TIMEOUT_EN
      idle_q   <= idle_d;
      to_q     <= expire;
`endif
    end
  end

  assign bus.key_buffer   = buf_q;
  assign bus.digit_count  = cnt_q;
  assign bus.buf_full     = (cnt_q == FullCnt);
  assign bus.commit_valid = cvalid_q;
  assign bus.commit_value = cval_q;
  assign bus.overflow     = ovf_q;
  assign bus.key_reject   = rej_q;
`ifdef KEYREG_TIMEOUT_EN
  assign bus.timeout      = to_q;
`endif

endmodule

// File: tb/tb_aclk_keyreg_n.sv
// Bench for aclk_keyreg_n: two instances (CLEAR_ON_COMMIT 0 and 1) share stimulus and are
// compared every cycle against a digit-array model, plus hand-computed literal checks.
module tb_aclk_keyreg_n;
  localparam int unsigned D    = 4;
  localparam int unsigned W    = 4;
  localparam int unsigned BW   = D * W;
  localparam int unsigned CW   = $clog2(D + 1);
  localparam int unsigned MAXK = 9;
  localparam int unsigned TO   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, shift, backspace, clear, load, commit;
  logic [W-1:0]  key;
  logic [BW-1:0] load_value;

  aclk_keyreg_n_if #(.DIGITS(D), .DIGIT_W(W)) bus0 ();
  aclk_keyreg_n_if #(.DIGITS(D), .DIGIT_W(W)) bus1 ();

  assign bus0.key = key;             assign bus1.key = key;
  assign bus0.shift = shift;         assign bus1.shift = shift;
  assign bus0.backspace = backspace; assign bus1.backspace = backspace;
  assign bus0.clear = clear;         assign bus1.clear = clear;
  assign bus0.load = load;           assign bus1.load = load;
  assign bus0.load_value = load_value;
  assign bus1.load_value = load_value;
  assign bus0.commit = commit;       assign bus1.commit = commit;

  aclk_keyreg_n #(.DIGITS(D), .DIGIT_W(W), .MAX_KEY(MAXK), .CLEAR_ON_COMMIT(1'b0),
                  .TIMEOUT_CYCLES(TO)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  aclk_keyreg_n #(.DIGITS(D), .DIGIT_W(W), .MAX_KEY(MAXK), .CLEAR_ON_COMMIT(1'b1),
                  .TIMEOUT_CYCLES(TO)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic [BW-1:0] kb [2];
  logic [BW-1:0] cval [2];
  logic [CW-1:0] cnt [2];
  logic          full [2], cv [2], ovf [2], rej [2];

  assign kb[0] = bus0.key_buffer;     assign kb[1] = bus1.key_buffer;
  assign cval[0] = bus0.commit_value; assign cval[1] = bus1.commit_value;
  assign cnt[0] = bus0.digit_count;   assign cnt[1] = bus1.digit_count;
  assign full[0] = bus0.buf_full;     assign full[1] = bus1.buf_full;
  assign cv[0] = bus0.commit_valid;   assign cv[1] = bus1.commit_valid;
  assign ovf[0] = bus0.overflow;      assign ovf[1] = bus1.overflow;
  assign rej[0] = bus0.key_reject;    assign rej[1] = bus1.key_reject;
`ifdef KEYREG_TIMEOUT_EN
  logic to [2];
  assign to[0] = bus0.timeout;        assign to[1] = bus1.timeout;
`endif

  // Model state: digit array (index 0 = rightmost) plus expected pulse/snapshot values.
  int            m_dig [2][D];
  int            m_cnt [2];
  int            m_idle [2];
  logic [BW-1:0] m_cval [2];
  bit            m_cv [2], m_ovf [2], m_rej [2], m_to [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  function automatic logic [BW-1:0] pack(int u);
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < D; i++) v[i*W +: W] = W'(m_dig[u][i]);
    return v;
  endfunction

  task automatic check(string name, int u, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s [inst %0d] t=%0t: got %0h, expected %0h", name, u, $time, got, exp);
    end
  endtask

  task automatic model_update();
    for (int u = 0; u < 2; u++) begin
      int nd [D];
      int nc;
      bit ok, ev, coc, ovf_n, rej_n, to_n;
      for (int i = 0; i < D; i++) nd[i] = m_dig[u][i];
      nc    = m_cnt[u];
      coc   = (u == 1);
      ok    = (int'(key) <= int'(MAXK));
      ovf_n = 1'b0;
      rej_n = 1'b0;
      to_n  = 1'b0;
      ev    = clear || load || commit || (backspace && nc > 0) || (shift && ok);
      if (commit) m_cval[u] = pack(u);
      m_cv[u] = commit;
      if (clear || (commit && coc)) begin
        for (int i = 0; i < D; i++) nd[i] = 0;
        nc = 0;
      end else if (load) begin
        for (int i = 0; i < D; i++) nd[i] = int'(load_value[i*W +: W]);
        nc = D;
      end else if (backspace) begin
        if (nc > 0) begin
          for (int i = 0; i < D - 1; i++) nd[i] = nd[i+1];
          nd[D-1] = 0;
          nc--;
        end
      end else if (shift) begin
        if (ok) begin
          for (int i = D - 1; i > 0; i--) nd[i] = nd[i-1];
          nd[0] = int'(key);
          if (nc == D) ovf_n = 1'b1;
          else nc++;
        end else begin
          rej_n = 1'b1;
        end
      end
`ifdef KEYREG_TIMEOUT_EN
      if (ev || m_cnt[u] == 0) m_idle[u] = 0;
      else if (m_idle[u] == TO - 1) begin
        for (int i = 0; i < D; i++) nd[i] = 0;
        nc = 0;
        to_n = 1'b1;
        m_idle[u] = 0;
      end else m_idle[u]++;
`else
      if (ev) m_idle[u] = 0;
`endif
      if (reset) begin
        for (int i = 0; i < D; i++) nd[i] = 0;
        nc = 0;
        ovf_n = 1'b0;
        rej_n = 1'b0;
        to_n = 1'b0;
        m_cval[u] = '0;
        m_cv[u] = 1'b0;
        m_idle[u] = 0;
      end
      for (int i = 0; i < D; i++) m_dig[u][i] = nd[i];
      m_cnt[u] = nc;
      m_ovf[u] = ovf_n;
      m_rej[u] = rej_n;
      m_to[u]  = to_n;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        check("key_buffer", u, 64'(kb[u]), 64'(pack(u)));
        check("digit_count", u, 64'(cnt[u]), 64'(m_cnt[u]));
        check("buf_full", u, 64'(full[u]), 64'(m_cnt[u] == D));
        check("commit_valid", u, 64'(cv[u]), 64'(m_cv[u]));
        check("commit_value", u, 64'(cval[u]), 64'(m_cval[u]));
        check("overflow", u, 64'(ovf[u]), 64'(m_ovf[u]));
        check("key_reject", u, 64'(rej[u]), 64'(m_rej[u]));
`ifdef KEYREG_TIMEOUT_EN
        check("timeout", u, 64'(to[u]), 64'(m_to[u]));
`endif
      end
    end
  end

  // Inputs change at the falling edge; the model advances just after the rising edge.
  task automatic drive(bit r, bit c, bit l, bit b, bit s, bit cm, logic [W-1:0] k,
                       logic [BW-1:0] lv);
    reset = r; clear = c; load = l; backspace = b; shift = s; commit = cm;
    key = k; load_value = lv;
    @(posedge clk);
    #1;
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic push(logic [W-1:0] k);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, k, '0);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < D; i++) m_dig[u][i] = 0;
      m_cnt[u] = 0; m_idle[u] = 0; m_cval[u] = '0;
      m_cv[u] = 1'b0; m_ovf[u] = 1'b0; m_rej[u] = 1'b0; m_to[u] = 1'b0;
    end
    reset = 1'b1; clear = 1'b0; load = 1'b0; backspace = 1'b0; shift = 1'b0;
    commit = 1'b0; key = '0; load_value = '0;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk_en = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    check("rst_kb", 0, 64'(kb[0]), 64'h0);
    check("rst_cnt", 1, 64'(cnt[1]), 64'h0);

    push(4'd1); push(4'd2); push(4'd3); push(4'd0);
    check("entry_kb", 0, 64'(kb[0]), 64'h1230);
    check("entry_kb", 1, 64'(kb[1]), 64'h1230);
    check("entry_model", 0, 64'(pack(0)), 64'h1230);
    check("entry_cnt", 0, 64'(cnt[0]), 64'd4);
    check("entry_full", 0, 64'(full[0]), 64'd1);
    check("entry_ovf", 0, 64'(ovf[0]), 64'd0);

    push(4'd5);
    check("ovf_kb", 0, 64'(kb[0]), 64'h2305);
    check("ovf_pulse", 0, 64'(ovf[0]), 64'd1);
    check("ovf_cnt", 0, 64'(cnt[0]), 64'd4);
    push(4'hC);
    check("rej_kb", 0, 64'(kb[0]), 64'h2305);
    check("rej_pulse", 0, 64'(rej[0]), 64'd1);
    check("ovf_end", 0, 64'(ovf[0]), 64'd0);
    idle();
    check("rej_end", 0, 64'(rej[0]), 64'd0);

    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    push(4'd1); push(4'd2); push(4'd3);
    check("bs_start", 0, 64'(kb[0]), 64'h0123);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    check("bs1", 0, 64'(kb[0]), 64'h0012);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    check("bs2", 0, 64'(kb[0]), 64'h0001);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    check("bs3", 0, 64'(kb[0]), 64'h0000);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    check("bs4_kb", 0, 64'(kb[0]), 64'h0000);
    check("bs4_cnt", 0, 64'(cnt[0]), 64'd0);

    push(4'd1); push(4'd2); push(4'd3); push(4'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7, '0);
    check("cmt_keep_kb", 0, 64'(kb[0]), 64'h2307);
    check("cmt_clr_kb", 1, 64'(kb[1]), 64'h0000);
    check("cmt_clr_cnt", 1, 64'(cnt[1]), 64'd0);
    check("cmt_valid", 0, 64'(cv[0]), 64'd1);
    check("cmt_value", 0, 64'(cval[0]), 64'h1230);
    check("cmt_value", 1, 64'(cval[1]), 64'h1230);
    idle();
    check("cmt_valid_end", 0, 64'(cv[0]), 64'd0);
    check("cmt_hold", 0, 64'(cval[0]), 64'h1230);

    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 16'h0745);
    check("ld_clr_kb", 0, 64'(kb[0]), 64'h0000);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 16'h0745);
    check("ld_kb", 1, 64'(kb[1]), 64'h0745);
    check("ld_cnt", 1, 64'(cnt[1]), 64'd4);
    push(4'd3);
    check("ld_shift", 0, 64'(kb[0]), 64'h7453);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, '0);
    check("rst_mid_kb", 0, 64'(kb[0]), 64'h0);
    check("rst_mid_cval", 0, 64'(cval[0]), 64'h0);
    check("rst_mid_cv", 0, 64'(cv[0]), 64'd0);

`ifdef KEYREG_TIMEOUT_EN
    idle();
    push(4'd9);
    repeat (7) idle();
    check("to_pre_kb", 0, 64'(kb[0]), 64'h0009);
    check("to_pre", 0, 64'(to[0]), 64'd0);
    idle();
    check("to_pulse", 0, 64'(to[0]), 64'd1);
    check("to_kb", 0, 64'(kb[0]), 64'h0000);
    idle();
    check("to_end", 0, 64'(to[0]), 64'd0);
    push(4'd9);
    repeat (7) idle();
    push(4'd1);
    check("to_saved", 0, 64'(to[0]), 64'd0);
    check("to_saved_kb", 0, 64'(kb[0]), 64'h0091);
`endif

    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 249) begin
        repeat (10) idle();
      end else begin
        drive($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 14) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 1) == 0, $urandom_range(0, 9) == 0,
              W'($urandom_range(0, 15)), BW'($urandom));
      end
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
